// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings for the data-memory arbiter: FSM states, requester ids
// and the word-alignment test used on the latched address.
package dmem_arb_pkg;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ACCESS = 2'b01;
  localparam logic [1:0] ST_RESP   = 2'b10;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: a lone requester always wins,
// and on contention the requester named by prio wins.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       prio,
  output logic       valid,
  output logic       winner
);

  assign valid = |req;

  always_comb begin
    winner = 1'b0;
    if (req == 2'b11) begin
      winner = prio;
    end else begin
      winner = req[1];
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port DataMemory between the CPU MEM stage (port 0) and a
// DMA/debug loader (port 1); one access per IDLE -> ACCESS -> RESP round.
//
// state     | meaning
// ST_IDLE   | arbitrate; latch winner's we/addr/wdata/id
// ST_ACCESS | memory cycle; write commits / read captured at closing edge
// ST_RESP   | gnt (+rvalid or err) pulse to the winner; no arbitration
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  r0_req,
  input  logic                  r1_req,
  input  logic                  r0_we,
  input  logic                  r1_we,
  input  logic [DATA_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r0_gnt,
  output logic                  r1_gnt,
  output logic                  r0_rvalid,
  output logic                  r1_rvalid,
  output logic                  r0_err,
  output logic                  r1_err,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_di,
  input  logic [DATA_WIDTH-1:0] mem_do
);

  // The memory's word index is taken from mem_addr, so its depth must fit the bus.
  if (ADDR_WIDTH + 2 > DATA_WIDTH) begin : g_cfg_check
    $error("dmem_arbiter: ADDR_WIDTH too large for DATA_WIDTH");
  end

  logic [1:0]            r_state;
  logic                  r_prio;
  logic                  r_id;
  logic                  r_we;
  logic [DATA_WIDTH-1:0] r_mem_addr;
  logic [DATA_WIDTH-1:0] r_mem_di;
  logic [1:0]            r_gnt;
  logic [1:0]            r_rvalid;
  logic [1:0]            r_err;
  logic [DATA_WIDTH-1:0] r_rdata0;
  logic [DATA_WIDTH-1:0] r_rdata1;

  logic w_valid;
  logic w_winner;
  logic w_aligned;
  logic w_read_ok;

  rr_pick2 u_pick (
    .req    ({r1_req, r0_req}),
    .prio   (r_prio),
    .valid  (w_valid),
    .winner (w_winner)
  );

  assign w_aligned = is_aligned(r_mem_addr[1:0]);
  assign w_read_ok = !r_we && w_aligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_prio     <= REQ_CPU;
      r_id       <= REQ_CPU;
      r_we       <= 1'b0;
      r_mem_addr <= '0;
      r_mem_di   <= '0;
      r_gnt      <= '0;
      r_rvalid   <= '0;
      r_err      <= '0;
      r_rdata0   <= '0;
      r_rdata1   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_valid) begin
            r_id       <= w_winner;
            r_we       <= (w_winner == REQ_DMA) ? r1_we    : r0_we;
            r_mem_addr <= (w_winner == REQ_DMA) ? r1_addr  : r0_addr;
            r_mem_di   <= (w_winner == REQ_DMA) ? r1_wdata : r0_wdata;
            r_prio     <= ~w_winner;
            r_state    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          r_gnt[r_id]    <= 1'b1;
          r_rvalid[r_id] <= w_read_ok;
          r_err[r_id]    <= !w_aligned;
          if (w_read_ok) begin
            if (r_id == REQ_DMA) r_rdata1 <= mem_do;
            else                 r_rdata0 <= mem_do;
          end
          r_state <= ST_RESP;
        end
        ST_RESP: begin
          r_gnt    <= '0;
          r_rvalid <= '0;
          r_err    <= '0;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Decoded from registers only, so reset drops the write strobe immediately.
  assign mem_we   = (r_state == ST_ACCESS) && r_we && w_aligned;
  assign mem_addr = r_mem_addr;
  assign mem_di   = r_mem_di;

  assign r0_gnt    = r_gnt[REQ_CPU];
  assign r1_gnt    = r_gnt[REQ_DMA];
  assign r0_rvalid = r_rvalid[REQ_CPU];
  assign r1_rvalid = r_rvalid[REQ_DMA];
  assign r0_err    = r_err[REQ_CPU];
  assign r1_err    = r_err[REQ_DMA];
  assign r0_rdata  = r_rdata0;
  assign r1_rdata  = r_rdata1;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter with a behavioural DataMemory whose word
// at byte address A initially holds 32'h1000_0000 | A.
module tb_dmem_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          r0_req = 1'b0, r1_req = 1'b0;
  logic          r0_we = 1'b0, r1_we = 1'b0;
  logic [DW-1:0] r0_addr = '0, r1_addr = '0;
  logic [DW-1:0] r0_wdata = '0, r1_wdata = '0;
  logic          r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_err, r1_err;
  logic [DW-1:0] r0_rdata, r1_rdata;
  logic          mem_we;
  logic [DW-1:0] mem_addr, mem_di, mem_do;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .r0_req(r0_req), .r1_req(r1_req),
    .r0_we(r0_we), .r1_we(r1_we),
    .r0_addr(r0_addr), .r1_addr(r1_addr),
    .r0_wdata(r0_wdata), .r1_wdata(r1_wdata),
    .r0_gnt(r0_gnt), .r1_gnt(r1_gnt),
    .r0_rvalid(r0_rvalid), .r1_rvalid(r1_rvalid),
    .r0_err(r0_err), .r1_err(r1_err),
    .r0_rdata(r0_rdata), .r1_rdata(r1_rdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_di(mem_di), .mem_do(mem_do)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [2**AW];
  assign mem_do = mem[mem_addr[AW+1:2]];

  initial begin
    for (int i = 0; i < 2**AW; i++) mem[i] = 32'h1000_0000 | (i * 4);
    forever begin
      @(posedge clk);
      if (mem_we) mem[mem_addr[AW+1:2]] <= mem_di;
    end
  end

  typedef struct packed {
    logic          port;
    logic          rvalid;
    logic          err;
    logic [DW-1:0] rdata;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   we_cnt = 0;
  int   t_first[2];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops one expectation per grant pulse.
  always @(negedge clk) begin
    if (mem_we) we_cnt++;
    if (rst_n) begin
      if (r0_gnt || r1_gnt) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_empty: grant %b with no expected entry", {r1_gnt, r0_gnt});
        end else begin
          mon_e = sb.pop_front();
          check("gnt_port", 32'({r1_gnt, r0_gnt}), 32'(mon_e.port ? 2'b10 : 2'b01));
          check("rvalid", 32'({r1_rvalid, r0_rvalid}),
                mon_e.rvalid ? 32'(mon_e.port ? 2'b10 : 2'b01) : 32'd0);
          check("err", 32'({r1_err, r0_err}),
                mon_e.err ? 32'(mon_e.port ? 2'b10 : 2'b01) : 32'd0);
          if (mon_e.rvalid) check("rdata", mon_e.port ? r1_rdata : r0_rdata, mon_e.rdata);
        end
      end else begin
        check("idle_pulses", 32'({r1_rvalid, r0_rvalid, r1_err, r0_err}), 32'd0);
      end
    end
  end

  task automatic drive(input int p, input logic req, input logic we,
                       input logic [DW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      r0_req = req; r0_we = we; r0_addr = a; r0_wdata = d;
    end else begin
      r1_req = req; r1_we = we; r1_addr = a; r1_wdata = d;
    end
  endtask

  task automatic push(input logic port, input logic rv, input logic er, input logic [DW-1:0] rd);
    exp_t e;
    e.port = port; e.rvalid = rv; e.err = er; e.rdata = rd;
    sb.push_back(e);
  endtask

  // Single access issued from mid-IDLE; grant expected 2 edges later.
  task automatic access(input int p, input logic we, input logic [DW-1:0] a, input logic [DW-1:0] d);
    int   n = 0;
    logic g = 1'b0;
    @(negedge clk);
    drive(p, 1'b1, we, a, d);
    while (!g && n < 20) begin
      @(negedge clk);
      n++;
      g = (p == 0) ? r0_gnt : r1_gnt;
    end
    if (!g) begin
      n_checks++;
      n_fail++;
      $display("FAIL port%0d_timeout: no grant after %0d cycles, expected 2", p, n);
    end else begin
      check("latency", 32'(n), 32'd2);
    end
    drive(p, 1'b0, we, a, d);
  endtask

  // Holds a read request until n grants have been seen on this port.
  task automatic port_run(input int p, input logic [DW-1:0] a, input int n);
    int   got = 0;
    int   waited = 0;
    logic g;
    drive(p, 1'b1, 1'b0, a, '0);
    while (got < n && waited < 60) begin
      @(negedge clk);
      waited++;
      g = (p == 0) ? r0_gnt : r1_gnt;
      if (g) begin
        if (got == 0) t_first[p] = cyc;
        got++;
      end
    end
    if (got < n) begin
      n_checks++;
      n_fail++;
      $display("FAIL port%0d_timeout: got %0d grants, expected %0d", p, got, n);
    end
    drive(p, 1'b0, 1'b0, a, '0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_pulses"}, 32'({r0_gnt, r1_gnt, r0_rvalid, r1_rvalid, r0_err, r1_err}), 32'd0);
    check({tag, "_r0_rdata"}, r0_rdata, 32'd0);
    check({tag, "_r1_rdata"}, r1_rdata, 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_di"}, mem_di, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int we_before;
    #1 rst_n = 1'b0;
    #2 check_all_zero("reset");
    repeat (2) @(negedge clk);

    // Contention straight out of reset: r0 first, then strict alternation.
    for (int k = 0; k < 3; k++) begin
      push(1'b0, 1'b1, 1'b0, 32'h1000_0000);
      push(1'b1, 1'b1, 1'b0, 32'h1000_0004);
    end
    rst_n = 1'b1;
    fork
      port_run(0, 32'd0, 3);
      port_run(1, 32'd4, 3);
    join
    check("contention_gap", 32'(t_first[1] - t_first[0]), 32'd3);

    push(1'b0, 1'b0, 1'b0, '0);
    access(0, 1'b1, 32'd8, 32'hDEAD_BEEF);
    push(1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF);
    access(0, 1'b0, 32'd8, '0);

    we_before = we_cnt;
    push(1'b1, 1'b0, 1'b1, '0);
    access(1, 1'b1, 32'd6, 32'hCAFE_F00D);
    check("misaligned_no_we", 32'(we_cnt - we_before), 32'd0);
    check("misaligned_r1_rdata_held", r1_rdata, 32'h1000_0004);
    push(1'b0, 1'b1, 1'b0, 32'h1000_0004);
    access(0, 1'b0, 32'd4, '0);

    push(1'b1, 1'b0, 1'b0, '0);
    access(1, 1'b1, 32'd12, 32'h1234_5678);
    push(1'b0, 1'b1, 1'b0, 32'h1234_5678);
    access(0, 1'b0, 32'd12, '0);

    // Reset lands in the ACCESS cycle of a write to 16.
    @(negedge clk);
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'd16, 32'hFFFF_FFFF);
    @(negedge clk);
    check("rst_mid_mem_we", 32'(mem_we), 32'd1);
    check("rst_mid_mem_addr", mem_addr, 32'd16);
    rst_n = 1'b0;
    #1 check_all_zero("rst_mid");
    drive(0, 1'b0, 1'b0, '0, '0);
    repeat (2) @(negedge clk);

    push(1'b0, 1'b1, 1'b0, 32'h1000_0010);
    push(1'b1, 1'b1, 1'b0, 32'h1234_5678);
    rst_n = 1'b1;
    fork
      port_run(0, 32'd16, 1);
      port_run(1, 32'd12, 1);
    join
    check("post_reset_gap", 32'(t_first[1] - t_first[0]), 32'd3);

    repeat (3) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-port `DataMemory` between the MIPS core's load/store stage (requester 0) and a DMA/debug loader (requester 1). It grants one access at a time with round-robin fairness and drives the memory's `we`/`addr`/`di` from registered state. Read data from `do` is captured and returned to the winning requester with a one-cycle valid pulse. It sits between the pipeline's MEM stage and the `DataMemory` instance.

## Interface
- `ADDR_WIDTH`, 6: `DataMemory` depth exponent, passed through unchanged to the memory instance.
- `DATA_WIDTH`, 32: data and address bus width.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `r0_req`, `r1_req`  in  1  access request; held until the matching `gnt`.
- `r0_we`, `r1_we`  in  1  1 = write, 0 = read; stable while `req` is high.
- `r0_addr`, `r1_addr`  in  DATA_WIDTH  byte address; stable while `req` is high.
- `r0_wdata`, `r1_wdata`  in  DATA_WIDTH  write data.
- `r0_gnt`, `r1_gnt`  out  1  one-cycle completion pulse.
- `r0_rvalid`, `r1_rvalid`  out  1  one-cycle pulse with `gnt` for a successful read.
- `r0_err`, `r1_err`  out  1  one-cycle pulse with `gnt` for a misaligned address.
- `r0_rdata`, `r1_rdata`  out  DATA_WIDTH  captured read data; holds until the next read to that port.
- `mem_we`  out  1  to `DataMemory` `we`.
- `mem_addr`  out  DATA_WIDTH  to `DataMemory` `addr`.
- `mem_di`  out  DATA_WIDTH  to `DataMemory` `di`.
- `mem_do`  in  DATA_WIDTH  from `DataMemory` `do`; combinational read.

## Operation
- FSM has 3 states.
  - IDLE: if any `req` is high, pick a winner, latch its `we`/`addr`/`wdata`/id into `mem_*` registers, and go to ACCESS. Otherwise stay in IDLE.
  - ACCESS: `mem_we` = latched `we` AND aligned. At the edge ending ACCESS:
    - on a read, capture `mem_do` into the winner's `rdata`;
    - set the winner's `gnt`, plus `rvalid` (aligned read) or `err` (misaligned);
    - go to RESP.
  - RESP: `gnt`/`rvalid`/`err` are high for this one cycle. No arbitration happens here. Always return to IDLE.
- Alignment: `addr[1:0] != 0` is misaligned.
  - `mem_we` stays 0, so no write happens and memory is unchanged.
  - `rdata` is not updated and `rvalid` stays 0.
- Round-robin:
  - A 1-bit `prio` names the preferred requester; reset value 0.
  - With a single request, that requester wins.
  - With both requesting, the `prio` requester wins.
  - After every grant, `prio` is set to the non-winner.
- `mem_addr`/`mem_di` hold their last latched values outside ACCESS. `mem_we` is 0 outside ACCESS.
- Requester rules:
  - Drop `req` in the cycle after `gnt`, or keep it high to issue a new access, which re-arbitrates in the following IDLE.
  - Changing `we`/`addr`/`wdata` while `req` is high and before `gnt` is a protocol violation. The arbiter uses the values sampled in IDLE.
  - A request dropped before `gnt` after it was latched still completes.

## Timing
- Latency: request sampled at edge E, mem access during cycle E..E+1, `gnt` high during cycle E+1..E+2. That is 2 cycles from `req` seen to `gnt` visible.
- Throughput: one access per 3 cycles.
- With both requesters always requesting, grants alternate 0,1,0,1…
- Write timing: memory is written at the edge ending ACCESS. A read issued next by either port observes the new data.
- Reset:
  - Asserting `rst_n` low at any time immediately forces IDLE, `prio`=0, and all outputs to 0: `gnt`, `rvalid`, `err`, `rdata`, `mem_we`, `mem_addr`, `mem_di`.
  - A write whose ACCESS cycle is cut by reset before its closing edge is not performed.
- Release: the first arbitration happens on the first rising edge with `rst_n` high.

## Structure
- Package `dmem_arb_pkg`:
  - state encoding localparams: `ST_IDLE`=2'b00, `ST_ACCESS`=2'b01, `ST_RESP`=2'b10;
  - requester ids `REQ_CPU`=0, `REQ_DMA`=1.
- One sub-module `rr_pick2`: combinational 2-way round-robin picker.
  - Inputs: `req[1:0]`, `prio`.
  - Outputs: `valid`, `winner`.
- FSM, `prio` register, latch registers, and per-port output registers live in `dmem_arbiter`.

## Test plan
- Single write then read, r0: write addr=8, wdata=32'hDEADBEEF.
  - `r0_gnt` pulses 2 cycles after `req`.
  - Read of addr=8 gives `r0_rvalid`=1, `r0_rdata`=32'hDEADBEEF.
- Contention from reset: both ports read, at addr=0 and addr=4, asserted in the same cycle.
  - r0 granted first, r1 granted 3 cycles later.
  - Grants continue alternating while both stay high for 6 accesses.
- Misaligned write: r1 writes addr=6.
  - `r1_gnt`=`r1_err`=1, `mem_we` never high.
  - A subsequent read of addr=4 returns the prior value.
- Cross-port coherence: r1 writes addr=12 with 32'h12345678, then r0 reads addr=12 → `r0_rdata`=32'h12345678.
- Reset mid-write: drop `rst_n` during ACCESS of a write to addr=16 with 32'hFFFFFFFF.
  - All outputs read 0 immediately.
  - After release, a read of addr=16 returns the old contents.
  - The first grant goes to r0 when both request.
